axi4_stream_mul_engine: RTL and testbench

//  AXI4-Stream multiply engine. Receives operands a and b as one framed packet of DSZ-bit beats.

---
 rtl/axi4_stream_mul_engine.sv | 196 +++++++++++++++++++
 tb/tb_axi4_stream_mul_engine.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_stream_mul_engine.sv
// AXI4-Stream shift-add multiplier: one framed operand packet in (a then b, LSB-first),
// one framed 2*SZ-bit product packet out. Optional stream-ID echo under AXIS_TID_EN.
module axi4_stream_mul_engine #(
  parameter int SZ    = 32,
  parameter int DSZ   = 8,
  parameter int STEP  = 1,
  parameter int TID_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DSZ-1:0]   s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
`ifdef AXIS_TID_EN
  input  logic [TID_W-1:0] s_tid,
`endif
  output logic [DSZ-1:0]   m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
`ifdef AXIS_TID_EN
  output logic [TID_W-1:0] m_tid,
`endif
  output logic             busy,
  output logic             err_framing,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int NB    = SZ / DSZ;
  localparam int NBEAT = 2 * NB;
  localparam int NSTEP = SZ / STEP;
  localparam int CW    = $clog2(NSTEP + NBEAT + 1);
  localparam int BW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;

  localparam logic [CW-1:0] LAST_BEAT = CW'(NBEAT - 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(NSTEP);

  generate
    if (SZ % DSZ != 0) begin : g_chk_dsz
      $error("SZ must be a multiple of DSZ");
    end
    if (SZ % STEP != 0) begin : g_chk_step
      $error("SZ must be a multiple of STEP");
    end
    if (TID_W < 1 || CNT_W < 1) begin : g_chk_w
      $error("TID_W and CNT_W must be positive");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_RX    = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CALC  = 2'd2,
    ST_TX    = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*SZ-1:0]    opnd_q, opnd_d;
  logic [2*SZ-1:0]    prod_q, prod_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;
`ifdef AXIS_TID_EN
  logic [TID_W-1:0]   tid_q, tid_d;
`endif

  logic               s_hs, m_hs, tx_act;
  logic [SZ-1:0]      mcand;
  logic [SZ+STEP-1:0] acc;
  logic [2*SZ+STEP-1:0] step_wide;
  logic [2*SZ-1:0]    step_res;
  logic [NBEAT-1:0][DSZ-1:0] prod_beats;
  logic [BW-1:0]      bidx;

  // Outputs are qualified by rst so the reset cycle itself shows idle values.
  assign s_tready    = !rst && (state_q == ST_RX || state_q == ST_DRAIN);
  assign tx_act      = !rst && (state_q == ST_TX);
  assign busy        = !rst && (state_q == ST_CALC || state_q == ST_TX);
  assign m_tvalid    = tx_act;
  assign m_tlast     = tx_act && (cnt_q == LAST_BEAT);
  assign prod_beats  = prod_q;
  assign bidx        = cnt_q[BW-1:0];
  assign m_tdata     = tx_act ? prod_beats[bidx] : '0;
  assign err_framing = err_q && !rst;
  assign done_cnt    = done_cnt_q;
`ifdef AXIS_TID_EN
  assign m_tid       = tx_act ? tid_q : '0;
`endif

  assign s_hs  = s_tvalid && s_tready;
  assign m_hs  = m_tvalid && m_tready;
  assign mcand = opnd_q[2*SZ-1:SZ];

  // Low half of prod_q holds the remaining multiplier bits; retire STEP of them per cycle.
  always_comb begin
    acc = {{STEP{1'b0}}, prod_q[2*SZ-1:SZ]};
    for (int j = 0; j < STEP; j++) begin
      if (prod_q[j]) acc = acc + ({{STEP{1'b0}}, mcand} << j);
    end
    step_wide = {acc, prod_q[SZ-1:0]} >> STEP;
    step_res  = step_wide[2*SZ-1:0];
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    opnd_d     = opnd_q;
    prod_d     = prod_q;
    err_d      = 1'b0;
    done_cnt_d = done_cnt_q;
`ifdef AXIS_TID_EN
    tid_d      = tid_q;
`endif
    case (state_q)
      ST_RX: begin
        if (s_hs) begin
          opnd_d = {s_tdata, opnd_q[2*SZ-1:DSZ]};
`ifdef AXIS_TID_EN
          if (cnt_q == '0) tid_d = s_tid;
`endif
          if (cnt_q == LAST_BEAT) begin
            cnt_d = '0;
            if (s_tlast) begin
              state_d = ST_CALC;
            end else begin
              state_d = ST_DRAIN;
              err_d   = 1'b1;
            end
          end else if (s_tlast) begin
            cnt_d = '0;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (s_hs && s_tlast) state_d = ST_RX;
      end
      ST_CALC: begin
        // Count 0 loads the multiplier; counts 1..NSTEP each retire STEP bits.
        if (cnt_q == '0) begin
          prod_d = {{SZ{1'b0}}, opnd_q[SZ-1:0]};
          cnt_d  = CW'(1);
        end else begin
          prod_d = step_res;
          if (cnt_q == LAST_STEP) begin
            cnt_d   = '0;
            state_d = ST_TX;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_TX: begin
        if (m_hs) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d      = '0;
            state_d    = ST_RX;
            done_cnt_d = done_cnt_q + CNT_W'(1);
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_RX;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RX;
      cnt_q      <= '0;
      opnd_q     <= '0;
      prod_q     <= '0;
      err_q      <= 1'b0;
      done_cnt_q <= '0;
`ifdef AXIS_TID_EN
      tid_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      opnd_q     <= opnd_d;
      prod_q     <= prod_d;
      err_q      <= err_d;
      done_cnt_q <= done_cnt_d;
`ifdef AXIS_TID_EN
      tid_q      <= tid_d;
`endif
    end
  end

endmodule

// File: tb/tb_axi4_stream_mul_engine.sv
// Randomized bench for axi4_stream_mul_engine (SZ=32, DSZ=8, STEP=1); model is plain a*b.
module tb_axi4_stream_mul_engine;
  localparam int SZ = 32, DSZ = 8, STEP = 1, TID_W = 4, CNT_W = 16;
  localparam int NBEAT = 2 * SZ / DSZ;
  localparam int LAT   = SZ / STEP + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [DSZ-1:0]   s_tdata;
  logic             s_tvalid, s_tlast;
  logic             s_tready;
  logic [TID_W-1:0] s_tid;
  logic [DSZ-1:0]   m_tdata;
  logic             m_tvalid, m_tlast;
  logic             m_tready;
  logic [TID_W-1:0] m_tid;
  logic             busy, err_framing;
  logic [CNT_W-1:0] done_cnt;

  always #5 clk = ~clk;

  axi4_stream_mul_engine #(.SZ(SZ), .DSZ(DSZ), .STEP(STEP), .TID_W(TID_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
`ifdef AXIS_TID_EN
    .s_tid(s_tid),
`endif
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
`ifdef AXIS_TID_EN
    .m_tid(m_tid),
`endif
    .busy(busy), .err_framing(err_framing), .done_cnt(done_cnt)
  );

  int checks = 0, errors = 0;
  int exp_done = 0, exp_err = 0;
  int err_seen = 0, err_double = 0, err_done_overlap = 0;
  logic err_prev = 1'b0;
  logic [CNT_W-1:0] done_prev = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL %s got 0x%0h want 0x%0h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (err_framing) err_seen++;
      if (err_framing && err_prev) err_double++;
      if (err_framing && done_cnt != done_prev) err_done_overlap++;
    end
    err_prev  = err_framing;
    done_prev = done_cnt;
  end

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa, wb;
    wa = {32'b0, a};
    wb = {32'b0, b};
    return wa * wb;
  endfunction

  // Sends nbeats beats; beats 0..7 carry {b,a} LSB-first, tlast on beat last_at (-1: never).
  task automatic send_pkt(input logic [31:0] a, input logic [31:0] b, input logic [TID_W-1:0] id,
                          input int nbeats, input int last_at);
    logic [63:0] ab;
    int w;
    ab = {b, a};
    for (int i = 0; i < nbeats; i++) begin
      while ($urandom_range(0, 3) == 0) begin
        s_tvalid = 1'b0;
        tick();
      end
      s_tvalid = 1'b1;
      s_tdata  = (i < NBEAT) ? ab[i*DSZ +: DSZ] : DSZ'($urandom);
      s_tlast  = (i == last_at);
      s_tid    = (i == 0) ? id : TID_W'($urandom_range(0, 15));
      w = 0;
      while (!s_tready && w < 100) begin
        tick();
        w++;
      end
      if (w >= 100) chk("s_tready_timeout", 64'(s_tready), 64'd1);
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // Collects the result packet with random backpressure; optional forced stall or reset abort.
  task automatic recv_pkt(input logic [63:0] want, input logic [TID_W-1:0] id, input int stall_beat,
                          input int stall_len, input int abort_beat, output logic [63:0] got);
    int n, k, cyc, stalled;
    got = '0;
    chk("busy_calc", 64'(busy), 64'd1);
    n = 0;
    while (!m_tvalid && n < 200) begin
      tick();
      n++;
    end
    chk("latency", 64'(n), 64'(LAT));
    k = 0; cyc = 0; stalled = 0;
    while (k < NBEAT && cyc < 400) begin
      if (k == abort_beat) begin
        rst = 1'b1;
        tick();
        chk("abort_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("abort_done_cnt", 64'(done_cnt), 64'd0);
        chk("abort_s_tready", 64'(s_tready), 64'd0);
        rst = 1'b0;
        #1;
        chk("abort_s_tready_rise", 64'(s_tready), 64'd1);
        exp_done = 0;
        m_tready = 1'b0;
        return;
      end
      if (k == stall_beat && stalled < stall_len) begin
        m_tready = 1'b0;
        stalled++;
      end else begin
        m_tready = ($urandom_range(0, 3) != 0);
      end
      chk("m_tvalid_hold", 64'(m_tvalid), 64'd1);
      chk("m_tdata", 64'(m_tdata), 64'(want[k*DSZ +: DSZ]));
      chk("m_tlast", 64'(m_tlast), 64'(k == NBEAT - 1));
      chk("s_tready_tx", 64'(s_tready), 64'd0);
`ifdef AXIS_TID_EN
      chk("m_tid", 64'(m_tid), 64'(id));
`endif
      if (m_tready) begin
        got[k*DSZ +: DSZ] = m_tdata;
        k++;
      end
      tick();
      cyc++;
    end
    m_tready = 1'b0;
    if (cyc >= 400) chk("rx_timeout", 64'(k), 64'(NBEAT));
    exp_done++;
    chk("done_cnt", 64'(done_cnt), 64'(exp_done));
    chk("busy_idle", 64'(busy), 64'd0);
    chk("s_tready_rx", 64'(s_tready), 64'd1);
    chk("m_tvalid_end", 64'(m_tvalid), 64'd0);
  endtask

  task automatic run_pkt(input logic [31:0] a, input logic [31:0] b, input logic [TID_W-1:0] id,
                         input int stall_beat, input int stall_len, output logic [63:0] got);
    send_pkt(a, b, id, NBEAT, NBEAT - 1);
    recv_pkt(model(a, b), id, stall_beat, stall_len, -1, got);
    chk("product", got, model(a, b));
  endtask

  task automatic idle_check(input int ncyc);
    int bad;
    bad = 0;
    repeat (ncyc) begin
      if (m_tvalid || busy) bad++;
      tick();
    end
    chk("no_output", 64'(bad), 64'd0);
    chk("err_count", 64'(err_seen), 64'(exp_err));
  endtask

  initial begin
    logic [63:0] got;
    logic [31:0] ra, rb;
    logic [TID_W-1:0] rid;
    rst = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tid = '0; m_tready = 1'b0;
    repeat (3) tick();
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_m_tlast", 64'(m_tlast), 64'd0);
    chk("rst_m_tdata", 64'(m_tdata), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_framing), 64'd0);
    chk("rst_done_cnt", 64'(done_cnt), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_s_tready", 64'(s_tready), 64'd1);

    run_pkt(32'd10234, 32'd566, 4'hA, -1, 0, got);
    chk("basic_const", got, 64'h0000_0000_0058_62BC);
    run_pkt(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h5, -1, 0, got);
    chk("max_const", got, 64'hFFFF_FFFE_0000_0001);
    run_pkt($urandom, $urandom, 4'h3, 3, 5, got);
    run_pkt(32'd0, $urandom, 4'h0, -1, 0, got);

    send_pkt($urandom, $urandom, 4'h1, 4, 3);
    exp_err++;
    idle_check(50);
    run_pkt($urandom, $urandom, 4'h2, -1, 0, got);

    send_pkt($urandom, $urandom, 4'h1, NBEAT, -1);
    exp_err++;
    chk("drain_s_tready", 64'(s_tready), 64'd1);
    send_pkt($urandom, $urandom, 4'h1, 3, 2);
    idle_check(50);
    run_pkt($urandom, $urandom, 4'h6, -1, 0, got);

    ra = $urandom; rb = $urandom;
    send_pkt(ra, rb, 4'h7, NBEAT, NBEAT - 1);
    recv_pkt(model(ra, rb), 4'h7, -1, 0, 4, got);
    idle_check(10);
    run_pkt(32'd123124, 32'd12412, 4'h9, -1, 0, got);

    run_pkt($urandom, $urandom, 4'hA, -1, 0, got);
    run_pkt($urandom, $urandom, 4'h1, -1, 0, got);
    run_pkt($urandom, $urandom, 4'h2, -1, 0, got);

    for (int p = 0; p < 20; p++) begin
      ra  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      rid = TID_W'($urandom_range(0, 15));
      run_pkt(ra, rb, rid, int'($urandom_range(0, NBEAT - 1)), int'($urandom_range(0, 4)), got);
    end

    tick();
    chk("err_total", 64'(err_seen), 64'(exp_err));
    chk("err_single_cycle", 64'(err_double), 64'd0);
    chk("err_done_exclusive", 64'(err_done_overlap), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

endmodule
